second_game_obstacle_field: RTL and testbench

Game-state stage feeding second_game_graphics. It holds the scrolling obstacle map, player X position, collision detection and game FSM. It answers the renderer's per-pixel obstacle query combinationally and advances the game once per frame. Obstacles scroll upward toward the player, who sits at the top of the 400x600 second-game region.

---
 rtl/second_game_obstacle_field.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_second_game_obstacle_field.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/second_game_obstacle_field.sv
`timescale 1ns/1ps
// second_game_obstacle_field
//   Game-state stage for the second game. It holds the scrolling obstacle map,
//   the player's horizontal position, collision detection and the game FSM.
//   It answers the renderer's per-pixel obstacle query combinationally and
//   advances the game once per frame tick. Obstacles scroll upward toward the
//   player, who sits near the top of the play field.
//
// Ports
//   clk, rst            system clock; synchronous active-high reset
//   i_frame_tick        one-cycle pulse per frame (vertical blanking)
//   i_start             start / restart request, level-sampled
//   i_left, i_right     movement buttons
//   i_disp_enbl         renderer pixel valid
//   i_screen_x/y        pixel being drawn
//   o_is_obstacle       queried pixel lies in a blocked cell (combinational)
//   o_screen_square_x   player centre x
//   o_playing           FSM in PLAY
//   o_game_over         FSM in CRASH
//   o_score             wall rows passed, saturating
module second_game_obstacle_field #(
  parameter int          SCREEN_WIDTH    = 400,
  parameter int          SCREEN_HEIGHT   = 600,
  parameter int          PLAYER_SIZE     = 20,
  parameter int          CELL_SIZE       = 16,
  parameter int          SCROLL_SPEED    = 2,
  parameter int          PLAYER_STEP     = 4,
  parameter int          GAP_CELLS       = 4,
  parameter int          OBSTACLE_PERIOD = 6,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_frame_tick,
  input  logic                              i_start,
  input  logic                              i_left,
  input  logic                              i_right,
  input  logic                              i_disp_enbl,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]   i_screen_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0]  i_screen_y,
  output logic                              o_is_obstacle,
  output logic [$clog2(SCREEN_WIDTH)-1:0]   o_screen_square_x,
  output logic                              o_playing,
  output logic                              o_game_over,
  output logic [15:0]                       o_score
);

  localparam int XW        = $clog2(SCREEN_WIDTH);
  localparam int XW1       = XW + 1;
  localparam int YW        = $clog2(SCREEN_HEIGHT);
  localparam int QW        = YW + 1;
  localparam int CW        = $clog2(CELL_SIZE);
  localparam int CW1       = CW + 1;
  localparam int COLS      = SCREEN_WIDTH / CELL_SIZE;
  localparam int CIW       = $clog2(COLS);
  localparam int ROWS      = (SCREEN_HEIGHT + CELL_SIZE - 1) / CELL_SIZE + 1;
  localparam int HW        = $clog2(ROWS);
  localparam int RCW       = (OBSTACLE_PERIOD > 1) ? $clog2(OBSTACLE_PERIOD) : 1;
  localparam int GAP_RANGE = COLS - GAP_CELLS + 1;

  localparam logic [XW-1:0]  X_CENTER    = XW'(SCREEN_WIDTH / 2);
  localparam logic [XW-1:0]  X_MIN       = XW'(PLAYER_SIZE);
  localparam logic [XW-1:0]  X_MAX       = XW'(SCREEN_WIDTH - 1 - PLAYER_SIZE);
  localparam logic [XW-1:0]  X_STEP      = XW'(PLAYER_STEP);
  localparam logic [XW-1:0]  COLS_X      = XW'(COLS);
  localparam logic [XW:0]    BOX_HALF    = XW1'(PLAYER_SIZE);
  localparam logic [YW-1:0]  HIT_Y_MAX   = YW'(PLAYER_SIZE + PLAYER_SIZE / 2);
  localparam logic [QW-1:0]  ROWS_Q      = QW'(ROWS);
  localparam logic [HW-1:0]  HEAD_LAST   = HW'(ROWS - 1);
  localparam logic [CW:0]    SCROLL_W    = CW1'(SCROLL_SPEED);
  localparam logic [CW:0]    CELL_W      = CW1'(CELL_SIZE);
  localparam logic [RCW-1:0] WALL_PHASE  = RCW'(OBSTACLE_PERIOD - 1);
  localparam logic [4:0]     GAP_RANGE_L = 5'(GAP_RANGE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2
  } state_t;

  // 16-bit Fibonacci LFSR step, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Wall row: every cell blocked except GAP_CELLS cells starting at gap
  function automatic logic [COLS-1:0] wall_row(input logic [4:0] gap);
    logic [COLS-1:0] row;
    row = '1;
    for (int c = 0; c < COLS; c++) begin
      if ((c >= int'(gap)) && (c < int'(gap) + GAP_CELLS)) begin
        row[c] = 1'b0;
      end else begin
        row[c] = 1'b1;
      end
    end
    return row;
  endfunction

  state_t          state_r, state_next_s;
  logic [COLS-1:0] store_r [ROWS];
  logic [HW-1:0]   head_r;
  logic [CW-1:0]   offset_r;
  logic [15:0]     lfsr_r;
  logic [RCW-1:0]  row_cnt_r;
  logic            hit_r;
  logic [XW-1:0]   sq_x_r;
  logic [15:0]     score_r;

  logic [QW-1:0]   wy_s, rel_s, row_sum_s, row_idx_s;
  logic [XW-1:0]   col_s;
  logic            is_obstacle_s;
  logic [XW:0]     px_s, sq_s;
  logic            collide_s;
  logic [XW-1:0]   x_next_s;
  logic [CW:0]     off_sum_s;
  logic [CW-1:0]   off_next_s;
  logic            row_wrap_s;
  logic [15:0]     lfsr_step_s;
  logic [4:0]      gap_raw_s, gap_start_s;
  logic            wall_due_s;
  logic [COLS-1:0] new_row_s;
  logic [HW-1:0]   head_next_s;
  logic [RCW-1:0]  row_cnt_next_s;

  // Pixel query: map screen y through scroll offset and circular head to a slot
  always_comb begin
    wy_s          = QW'(i_screen_y) + QW'(offset_r);
    rel_s         = wy_s >> CW;
    row_sum_s     = QW'(head_r) + rel_s;
    row_idx_s     = row_sum_s;
    col_s         = i_screen_x >> CW;
    is_obstacle_s = 1'b0;
    if (row_sum_s >= ROWS_Q) begin
      row_idx_s = row_sum_s - ROWS_Q;
    end else begin
      row_idx_s = row_sum_s;
    end
    // Out-of-field coordinates never read the store
    if (i_disp_enbl && (col_s < COLS_X) && (row_idx_s < ROWS_Q)) begin
      is_obstacle_s = store_r[row_idx_s[HW-1:0]][col_s[CIW-1:0]];
    end else begin
      is_obstacle_s = 1'b0;
    end
  end

  // Collision window around the player; widened so x-PLAYER_SIZE cannot wrap
  always_comb begin
    px_s      = XW1'(i_screen_x);
    sq_s      = XW1'(sq_x_r);
    collide_s = i_disp_enbl && is_obstacle_s &&
                (px_s + BOX_HALF >= sq_s) && (px_s <= sq_s + BOX_HALF) &&
                (i_screen_y <= HIT_Y_MAX);
  end

  // Player movement with clamping to the visible field
  always_comb begin
    x_next_s = sq_x_r;
    if (i_left && !i_right) begin
      if (sq_x_r >= X_MIN + X_STEP) begin
        x_next_s = sq_x_r - X_STEP;
      end else begin
        x_next_s = X_MIN;
      end
    end else if (i_right && !i_left) begin
      if (sq_x_r <= X_MAX - X_STEP) begin
        x_next_s = sq_x_r + X_STEP;
      end else begin
        x_next_s = X_MAX;
      end
    end else begin
      x_next_s = sq_x_r;
    end
  end

  // Scroll offset and content of the row generated when a cell boundary is crossed
  always_comb begin
    off_sum_s   = CW1'(offset_r) + SCROLL_W;
    row_wrap_s  = 1'b0;
    off_next_s  = offset_r;
    lfsr_step_s = lfsr_next(lfsr_r);
    gap_raw_s   = lfsr_step_s[4:0];
    gap_start_s = gap_raw_s;
    wall_due_s  = (row_cnt_r == WALL_PHASE);
    new_row_s   = '0;
    if (off_sum_s >= CELL_W) begin
      row_wrap_s = 1'b1;
      off_next_s = CW'(off_sum_s - CELL_W);
    end else begin
      row_wrap_s = 1'b0;
      off_next_s = CW'(off_sum_s);
    end
    // Fold the 5-bit random value into the legal gap start range
    if (gap_raw_s >= GAP_RANGE_L) begin
      gap_start_s = gap_raw_s - GAP_RANGE_L;
    end else begin
      gap_start_s = gap_raw_s;
    end
    if (wall_due_s) begin
      new_row_s      = wall_row(gap_start_s);
      row_cnt_next_s = '0;
    end else begin
      new_row_s      = '0;
      row_cnt_next_s = row_cnt_r + RCW'(1);
    end
    if (head_r == HEAD_LAST) begin
      head_next_s = '0;
    end else begin
      head_next_s = head_r + HW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_next_s = PLAY;
        end else begin
          state_next_s = IDLE;
        end
      end
      PLAY: begin
        if (i_frame_tick && hit_r) begin
          state_next_s = CRASH;
        end else begin
          state_next_s = PLAY;
        end
      end
      CRASH: begin
        if (i_start) begin
          state_next_s = PLAY;
        end else begin
          state_next_s = CRASH;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Game datapath: obstacle store, scroll, player, LFSR, score, hit flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        store_r[r] <= '0;
      end
      head_r    <= '0;
      offset_r  <= '0;
      lfsr_r    <= LFSR_SEED;
      row_cnt_r <= '0;
      hit_r     <= 1'b0;
      sq_x_r    <= X_CENTER;
      score_r   <= 16'd0;
    end else begin
      case (state_r)
        PLAY: begin
          if (i_frame_tick) begin
            // A pending hit ends the game and freezes motion on this tick
            hit_r <= 1'b0;
            if (!hit_r) begin
              sq_x_r   <= x_next_s;
              offset_r <= off_next_s;
              if (row_wrap_s) begin
                store_r[head_r] <= new_row_s;
                head_r          <= head_next_s;
                lfsr_r          <= lfsr_step_s;
                row_cnt_r       <= row_cnt_next_s;
                if (wall_due_s && (score_r != 16'hFFFF)) begin
                  score_r <= score_r + 16'd1;
                end
              end
            end
          end else if (collide_s) begin
            hit_r <= 1'b1;
          end
        end
        CRASH: begin
          // Restart keeps the LFSR running so the next game differs
          if (i_start) begin
            for (int r = 0; r < ROWS; r++) begin
              store_r[r] <= '0;
            end
            head_r    <= '0;
            offset_r  <= '0;
            row_cnt_r <= '0;
            score_r   <= 16'd0;
            sq_x_r    <= X_CENTER;
            hit_r     <= 1'b0;
          end
        end
        default: begin
          hit_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_is_obstacle     = is_obstacle_s;
  assign o_screen_square_x = sq_x_r;
  assign o_playing         = (state_r == PLAY);
  assign o_game_over       = (state_r == CRASH);
  assign o_score           = score_r;

endmodule

// File: tb/tb_second_game_obstacle_field.sv
`timescale 1ns/1ps
// Directed testbench for second_game_obstacle_field.
module tb_second_game_obstacle_field;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_frame_tick;
  logic        i_start;
  logic        i_left;
  logic        i_right;
  logic        i_disp_enbl;
  logic [8:0]  i_screen_x;
  logic [9:0]  i_screen_y;
  logic        o_is_obstacle;
  logic [8:0]  o_screen_square_x;
  logic        o_playing;
  logic        o_game_over;
  logic [15:0] o_score;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  second_game_obstacle_field dut (
    .clk               (clk),
    .rst               (rst),
    .i_frame_tick      (i_frame_tick),
    .i_start           (i_start),
    .i_left            (i_left),
    .i_right           (i_right),
    .i_disp_enbl       (i_disp_enbl),
    .i_screen_x        (i_screen_x),
    .i_screen_y        (i_screen_y),
    .o_is_obstacle     (o_is_obstacle),
    .o_screen_square_x (o_screen_square_x),
    .o_playing         (o_playing),
    .o_game_over       (o_game_over),
    .o_score           (o_score)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    i_frame_tick = 1'b1;
    cyc();
    i_frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  // Sample all 25 cells of the row under screen line y
  task automatic read_row(input logic [9:0] y, output logic [24:0] v);
    i_disp_enbl = 1'b1;
    i_screen_y  = y;
    for (int c = 0; c < 25; c++) begin
      i_screen_x = 9'(c * 16 + 8);
      #1;
      v[c] = o_is_obstacle;
    end
    i_disp_enbl = 1'b0;
  endtask

  // Present one pixel across a clock edge (lets the hit flag latch)
  task automatic probe(input logic [8:0] x, input logic [9:0] y, output logic obs);
    i_screen_x  = x;
    i_screen_y  = y;
    i_disp_enbl = 1'b1;
    #1;
    obs = o_is_obstacle;
    cyc();
    i_disp_enbl = 1'b0;
  endtask

  task automatic test_reset();
    logic obs;
    do_reset();
    tests++; if (o_screen_square_x !== 9'd200) begin fails++; $display("FAIL reset_x: got %0d expected 200", o_screen_square_x); end
    tests++; if (o_score !== 16'd0) begin fails++; $display("FAIL reset_score: got %0d expected 0", o_score); end
    tests++; if (o_playing !== 1'b0) begin fails++; $display("FAIL reset_playing: got %0b expected 0", o_playing); end
    tests++; if (o_game_over !== 1'b0) begin fails++; $display("FAIL reset_game_over: got %0b expected 0", o_game_over); end
    tests++; if (dut.lfsr_r !== 16'hACE1) begin fails++; $display("FAIL reset_lfsr: got %h expected ace1", dut.lfsr_r); end
    probe(9'd0, 10'd0, obs);
    tests++; if (obs !== 1'b0) begin fails++; $display("FAIL reset_query_0_0: got %0b expected 0", obs); end
    probe(9'd399, 10'd599, obs);
    tests++; if (obs !== 1'b0) begin fails++; $display("FAIL reset_query_399_599: got %0b expected 0", obs); end
    // Frame ticks and buttons in IDLE change nothing
    i_right = 1'b1;
    ticks(3);
    i_right = 1'b0;
    tests++; if (o_screen_square_x !== 9'd200) begin fails++; $display("FAIL idle_tick_x: got %0d expected 200", o_screen_square_x); end
    tests++; if (dut.offset_r !== 4'd0) begin fails++; $display("FAIL idle_tick_offset: got %0d expected 0", dut.offset_r); end
    tests++; if (o_playing !== 1'b0) begin fails++; $display("FAIL idle_tick_playing: got %0b expected 0", o_playing); end
  endtask

  task automatic test_scroll_gen();
    logic [24:0] v;
    logic obs;
    pulse_start();
    tests++; if (o_playing !== 1'b1) begin fails++; $display("FAIL start_playing: got %0b expected 1", o_playing); end
    ticks(8);
    tests++; if (dut.head_r !== 6'd1) begin fails++; $display("FAIL gen1_head: got %0d expected 1", dut.head_r); end
    tests++; if (dut.offset_r !== 4'd0) begin fails++; $display("FAIL gen1_offset: got %0d expected 0", dut.offset_r); end
    tests++; if (o_score !== 16'd0) begin fails++; $display("FAIL gen1_score: got %0d expected 0", o_score); end
    ticks(40);
    tests++; if (dut.head_r !== 6'd6) begin fails++; $display("FAIL gen6_head: got %0d expected 6", dut.head_r); end
    tests++; if (o_score !== 16'd1) begin fails++; $display("FAIL gen6_score: got %0d expected 1", o_score); end
    // Start while playing is ignored
    pulse_start();
    tests++; if (dut.head_r !== 6'd6 || o_playing !== 1'b1) begin fails++; $display("FAIL start_in_play: head %0d playing %0b expected 6 1", dut.head_r, o_playing); end
    ticks(5);
    tests++; if (dut.offset_r !== 4'd10) begin fails++; $display("FAIL scroll_offset: got %0d expected 10", dut.offset_r); end
    // First wall (LFSR step 6 = 0x3879, L=25, gap 3..6) now at the bottom line
    read_row(10'd599, v);
    tests++; if (v !== 25'h1FFFF87) begin fails++; $display("FAIL first_wall: got %h expected 1ffff87", v); end
    read_row(10'd590, v);
    tests++; if (v !== 25'h0) begin fails++; $display("FAIL row_above_wall: got %h expected 0", v); end
    i_screen_y = 10'd599; i_screen_x = 9'd400; i_disp_enbl = 1'b1; #1;
    obs = o_is_obstacle;
    i_disp_enbl = 1'b0;
    tests++; if (obs !== 1'b0) begin fails++; $display("FAIL col_out_of_range: got %0b expected 0", obs); end
    i_screen_x = 9'd200; #1;
    tests++; if (o_is_obstacle !== 1'b0) begin fails++; $display("FAIL disp_disabled: got %0b expected 0", o_is_obstacle); end
  endtask

  task automatic test_wrap();
    logic [24:0] v, expv;
    int z;
    ticks(311 - 53);
    tests++; if (dut.head_r !== 6'd38) begin fails++; $display("FAIL wrap_head38: got %0d expected 38", dut.head_r); end
    tick();
    tests++; if (dut.head_r !== 6'd0) begin fails++; $display("FAIL wrap_head0: got %0d expected 0", dut.head_r); end
    ticks(341 - 312);
    tests++; if (dut.head_r !== 6'd3 || dut.offset_r !== 4'd10) begin fails++; $display("FAIL wrap_pos: head %0d offset %0d expected 3 10", dut.head_r, dut.offset_r); end
    tests++; if (o_score !== 16'd7) begin fails++; $display("FAIL wrap_score: got %0d expected 7", o_score); end
    // y=599 lands on slot 2 (head 3 + rel 38 - 39), the wall written by row 42
    read_row(10'd599, v);
    z = 25;
    for (int c = 24; c >= 0; c--) if (v[c] == 1'b0) z = c;
    expv = 25'h1FFFFFF & ~(25'hF << z);
    tests++; if (v !== expv || z > 21) begin fails++; $display("FAIL wrap_wall_shape: got %h gap_start %0d", v, z); end
    read_row(10'd590, v);
    tests++; if (v !== 25'h0) begin fails++; $display("FAIL wrap_empty_row: got %h expected 0", v); end
  endtask

  task automatic test_clamp();
    do_reset();
    pulse_start();
    i_right = 1'b1;
    tick();
    tests++; if (o_screen_square_x !== 9'd204) begin fails++; $display("FAIL right_1: got %0d expected 204", o_screen_square_x); end
    tick();
    tests++; if (o_screen_square_x !== 9'd208) begin fails++; $display("FAIL right_2: got %0d expected 208", o_screen_square_x); end
    ticks(42);
    tests++; if (o_screen_square_x !== 9'd376) begin fails++; $display("FAIL right_44: got %0d expected 376", o_screen_square_x); end
    tick();
    tests++; if (o_screen_square_x !== 9'd379) begin fails++; $display("FAIL right_clamp: got %0d expected 379", o_screen_square_x); end
    ticks(15);
    tests++; if (o_screen_square_x !== 9'd379) begin fails++; $display("FAIL right_stick: got %0d expected 379", o_screen_square_x); end
    i_left = 1'b1;
    ticks(3);
    tests++; if (o_screen_square_x !== 9'd379) begin fails++; $display("FAIL both_hold: got %0d expected 379", o_screen_square_x); end
    i_right = 1'b0;
    tick();
    tests++; if (o_screen_square_x !== 9'd375) begin fails++; $display("FAIL left_1: got %0d expected 375", o_screen_square_x); end
    i_left = 1'b0;
    tick();
    tests++; if (o_screen_square_x !== 9'd375) begin fails++; $display("FAIL none_hold: got %0d expected 375", o_screen_square_x); end
    i_left = 1'b1;
    ticks(100);
    i_left = 1'b0;
    tests++; if (o_screen_square_x !== 9'd20) begin fails++; $display("FAIL left_clamp: got %0d expected 20", o_screen_square_x); end
  endtask

  task automatic test_collision();
    logic obs;
    do_reset();
    pulse_start();
    // 43 rows: head 4, first wall (slot 5, gap 3..6) sits in rows y=16..31
    ticks(344);
    tests++; if (dut.head_r !== 6'd4 || dut.offset_r !== 4'd0) begin fails++; $display("FAIL col_pos: head %0d offset %0d expected 4 0", dut.head_r, dut.offset_r); end
    probe(9'd200, 10'd31, obs);
    tests++; if (obs !== 1'b1) begin fails++; $display("FAIL wall_at_y31: got %0b expected 1", obs); end
    probe(9'd179, 10'd20, obs);
    tests++; if (obs !== 1'b1) begin fails++; $display("FAIL wall_at_x179: got %0b expected 1", obs); end
    probe(9'd221, 10'd20, obs);
    tests++; if (obs !== 1'b1) begin fails++; $display("FAIL wall_at_x221: got %0b expected 1", obs); end
    tick();
    tests++; if (o_playing !== 1'b1 || o_game_over !== 1'b0) begin fails++; $display("FAIL near_miss_no_crash: playing %0b over %0b expected 1 0", o_playing, o_game_over); end
    tests++; if (dut.offset_r !== 4'd2) begin fails++; $display("FAIL near_miss_offset: got %0d expected 2", dut.offset_r); end
    probe(9'd200, 10'd30, obs);
    tests++; if (obs !== 1'b0) begin fails++; $display("FAIL empty_at_y30: got %0b expected 0", obs); end
    probe(9'd220, 10'd29, obs);
    tests++; if (obs !== 1'b1) begin fails++; $display("FAIL wall_at_hit: got %0b expected 1", obs); end
    tests++; if (o_playing !== 1'b1) begin fails++; $display("FAIL hit_waits_tick: got %0b expected 1", o_playing); end
    tick();
    tests++; if (o_game_over !== 1'b1 || o_playing !== 1'b0) begin fails++; $display("FAIL crash: over %0b playing %0b expected 1 0", o_game_over, o_playing); end
    tests++; if (dut.offset_r !== 4'd2 || o_screen_square_x !== 9'd200) begin fails++; $display("FAIL crash_tick_frozen: offset %0d x %0d expected 2 200", dut.offset_r, o_screen_square_x); end
    i_right = 1'b1;
    ticks(3);
    i_right = 1'b0;
    tests++; if (dut.offset_r !== 4'd2 || o_screen_square_x !== 9'd200 || dut.head_r !== 6'd4) begin fails++; $display("FAIL crash_frozen: offset %0d x %0d head %0d expected 2 200 4", dut.offset_r, o_screen_square_x, dut.head_r); end
    tests++; if (o_score !== 16'd7) begin fails++; $display("FAIL crash_score: got %0d expected 7", o_score); end
  endtask

  task automatic test_restart();
    logic [24:0] v;
    pulse_start();
    tests++; if (o_playing !== 1'b1 || o_game_over !== 1'b0) begin fails++; $display("FAIL restart_state: playing %0b over %0b expected 1 0", o_playing, o_game_over); end
    tests++; if (o_score !== 16'd0 || o_screen_square_x !== 9'd200) begin fails++; $display("FAIL restart_score_x: score %0d x %0d expected 0 200", o_score, o_screen_square_x); end
    tests++; if (dut.head_r !== 6'd0 || dut.offset_r !== 4'd0) begin fails++; $display("FAIL restart_head_offset: head %0d offset %0d expected 0 0", dut.head_r, dut.offset_r); end
    tests++; if (dut.lfsr_r === 16'hACE1) begin fails++; $display("FAIL restart_lfsr_reseeded: got %h expected not ace1", dut.lfsr_r); end
    read_row(10'd20, v);
    tests++; if (v !== 25'h0) begin fails++; $display("FAIL restart_store_top: got %h expected 0", v); end
    read_row(10'd599, v);
    tests++; if (v !== 25'h0) begin fails++; $display("FAIL restart_store_bottom: got %h expected 0", v); end
    ticks(8);
    tests++; if (o_playing !== 1'b1 || dut.head_r !== 6'd1) begin fails++; $display("FAIL restart_runs: playing %0b head %0d expected 1 1", o_playing, dut.head_r); end
  endtask

  task automatic test_midgame_reset();
    i_right = 1'b1;
    ticks(3);
    tests++; if (o_screen_square_x !== 9'd212) begin fails++; $display("FAIL pre_reset_x: got %0d expected 212", o_screen_square_x); end
    rst = 1'b1;
    i_frame_tick = 1'b1;
    cyc();
    rst = 1'b0;
    i_frame_tick = 1'b0;
    i_right = 1'b0;
    tests++; if (o_screen_square_x !== 9'd200 || o_playing !== 1'b0 || o_game_over !== 1'b0) begin fails++; $display("FAIL midreset_outputs: x %0d playing %0b over %0b expected 200 0 0", o_screen_square_x, o_playing, o_game_over); end
    tests++; if (dut.head_r !== 6'd0 || dut.offset_r !== 4'd0 || o_score !== 16'd0) begin fails++; $display("FAIL midreset_state: head %0d offset %0d score %0d expected 0 0 0", dut.head_r, dut.offset_r, o_score); end
    tests++; if (dut.lfsr_r !== 16'hACE1) begin fails++; $display("FAIL midreset_lfsr: got %h expected ace1", dut.lfsr_r); end
  endtask

  initial begin
    rst = 1'b1; i_frame_tick = 1'b0; i_start = 1'b0; i_left = 1'b0; i_right = 1'b0;
    i_disp_enbl = 1'b0; i_screen_x = 9'd0; i_screen_y = 10'd0;
    test_reset();
    test_scroll_gen();
    test_wrap();
    test_clamp();
    test_collision();
    test_restart();
    test_midgame_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
